// File: rtl/muldiv_pkg.sv
// Shared types, constants and helpers for the iterative M-extension multiply/divide unit.
// Combinational definitions only: no latency and no handshake of its own.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int          MULDIV_ITER   = 32;
  localparam logic [31:0] MULDIV_DIV0_Q = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// Radix-2 shift datapath: shift-add multiply or restoring divide, one step per step_i.
// Loads in one cycle, 32 steps to a result; no backpressure, the controller sequences it.
module muldiv_shift_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        div_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] acc_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] m_q, m_d;
  logic        div_q, div_d;
  logic [32:0] sum;
  logic [33:0] diff;

  // Multiply: {hi,lo} = {partial, multiplier}; divide: {hi,lo} = {remainder, dividend/quotient}.
  always_comb begin
    acc_d = acc_q;
    m_d   = m_q;
    div_d = div_q;
    sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
    diff  = {1'b0, acc_q[63:31]} - {2'b00, m_q};
    if (load_i) begin
      div_d = div_i;
      m_d   = div_i ? b_i : a_i;
      acc_d = {32'd0, (div_i ? a_i : b_i)};
    end else if (step_i) begin
      if (div_q) begin
        acc_d = diff[33] ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
      div_q <= div_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_controller.sv
// RISC-V M-extension unit: 33 stall cycles then a one-cycle MulDivDone; div-by-zero/overflow take 1.
// Stalls the pipeline while busy; Kill aborts. MULDIV_FAST_MUL_EN selects a 1-cycle multiplier.
module muldiv_controller
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MulDivE,
  input  logic [2:0]  Funct3E,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic [4:0]  WriteRegE,
  input  logic        Kill,
  output logic        MulDivStall,
  output logic        MulDivDone,
  output logic [31:0] MulDivResult,
  output logic [4:0]  MulDivWriteReg
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q;
  logic [4:0]  wr_q;
  logic        neg_q, spec_q;
  logic [31:0] spec_res_q;

  logic        accept, special;
  logic [31:0] spec_res;
  logic        is_div, a_sgn, b_sgn, a_neg, b_neg, neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] acc, prod;
  logic [31:0] res;

  assign is_div = Funct3E[2];
  assign a_sgn  = is_div ? ~Funct3E[0] : (Funct3E != F3_MULHU);
  assign b_sgn  = is_div ? ~Funct3E[0] : ~Funct3E[1];
  assign a_neg  = a_sgn & SrcAE[31];
  assign b_neg  = b_sgn & SrcBE[31];
  assign a_mag  = neg32(SrcAE, a_neg);
  assign b_mag  = neg32(SrcBE, b_neg);
  // Remainder follows the dividend sign; quotient and product follow the sign XOR.
  assign neg    = (is_div && Funct3E[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [65:0] fast_a, fast_b, fast_p;
  assign fast_a = {{34{a_sgn & SrcAE[31]}}, SrcAE};
  assign fast_b = {{34{b_sgn & SrcBE[31]}}, SrcBE};
  assign fast_p = fast_a * fast_b;
`endif

  always_comb begin
    special  = 1'b0;
    spec_res = '0;
    if (is_div) begin
      if (SrcBE == 32'd0) begin
        special  = 1'b1;
        spec_res = Funct3E[1] ? SrcAE : MULDIV_DIV0_Q;
      end else if (a_sgn && SrcAE == 32'h8000_0000 && SrcBE == 32'hFFFF_FFFF) begin
        special  = 1'b1;
        spec_res = Funct3E[1] ? 32'd0 : 32'h8000_0000;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      special  = 1'b1;
      spec_res = (Funct3E == F3_MUL) ? fast_p[31:0] : fast_p[63:32];
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    MulDivStall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MulDivE && !Kill) begin
          accept      = 1'b1;
          MulDivStall = 1'b1;
          cnt_d       = 5'd0;
          state_d     = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        MulDivStall = 1'b1;
        cnt_d       = cnt_q + 5'd1;
        if (cnt_q == 5'(MULDIV_ITER - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (Kill) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      wr_q       <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        f3_q       <= Funct3E;
        wr_q       <= WriteRegE;
        neg_q      <= neg;
        spec_q     <= special;
        spec_res_q <= spec_res;
      end
    end
  end

  muldiv_shift_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept && !special),
    .step_i (state_q == S_CALC),
    .div_i  (is_div),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .acc_o  (acc)
  );

  always_comb begin
    prod = neg_q ? (~acc + 64'd1) : acc;
    res  = '0;
    if (spec_q) begin
      res = spec_res_q;
    end else if (!f3_q[2]) begin
      res = (f3_q == F3_MUL) ? prod[31:0] : prod[63:32];
    end else begin
      res = neg32(f3_q[1] ? acc[63:32] : acc[31:0], neg_q);
    end
  end

  assign MulDivDone     = (state_q == S_DONE) && !Kill;
  assign MulDivResult   = MulDivDone ? res : 32'd0;
  assign MulDivWriteReg = (state_q == S_IDLE) ? 5'd0 : wr_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller: directed vectors, corner sequences, random ops vs model.
module tb_muldiv_controller;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MulDivE = 1'b0;
  logic [2:0]  Funct3E = '0;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic [4:0]  WriteRegE = '0;
  logic        Kill = 1'b0;
  logic        MulDivStall, MulDivDone;
  logic [31:0] MulDivResult;
  logic [4:0]  MulDivWriteReg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  muldiv_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .MulDivE        (MulDivE),
    .Funct3E        (Funct3E),
    .SrcAE          (SrcAE),
    .SrcBE          (SrcBE),
    .WriteRegE      (WriteRegE),
    .Kill           (Kill),
    .MulDivStall    (MulDivStall),
    .MulDivDone     (MulDivDone),
    .MulDivResult   (MulDivResult),
    .MulDivWriteReg (MulDivWriteReg)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_stall;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Architectural result from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_stall_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_STALL;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one op at the next cycle and follows it to MulDivDone; MulDivE is left at 'hold'.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wr, input bit hold,
                        input logic [31:0] exp_res, input int exp_stall);
    int cyc, stalls;
    bit seen;
    cyc = 0; stalls = 0; seen = 0;
    @(posedge clk); #1;
    Funct3E = f; SrcAE = a; SrcBE = b; WriteRegE = wr; MulDivE = 1'b1; Kill = 1'b0;
    while (!seen && cyc < 60) begin
      cyc++;
      @(negedge clk);
      if (cyc == 1) check({name, " wreg_accept"}, 32'(MulDivWriteReg), 32'd0);
      if (MulDivDone) begin
        seen = 1'b1;
      end else begin
        if (MulDivStall) stalls++;
        @(posedge clk); #1;
        MulDivE = hold;
      end
    end
    if (!seen) begin
      check({name, " done_timeout"}, 32'(cyc), 32'(exp_stall + 1));
    end else begin
      check({name, " result"}, MulDivResult, exp_res);
      check({name, " stalls"}, 32'(stalls), 32'(exp_stall));
      check({name, " done_cycle"}, 32'(cyc), 32'(exp_stall + 1));
      check({name, " wreg_done"}, 32'(MulDivWriteReg), 32'(wr));
      check({name, " stall_in_done"}, 32'(MulDivStall), 32'd0);
    end
  endtask

  initial begin
    vec_t vecs[10];
    int dones;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vecs[0] = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33};
    vecs[1] = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33};
    vecs[2] = '{3'd5, 32'd100,       32'd0,          32'hFFFF_FFFF, 1};
    vecs[3] = '{3'd7, 32'd100,       32'd0,          32'd100,       1};
    vecs[4] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[5] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[6] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALL};
    vecs[7] = '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, MUL_STALL};
    vecs[8] = '{3'd0, 32'hFFFF_FFFA, 32'd7,          32'hFFFF_FFD6, MUL_STALL};
    vecs[9] = '{3'd4, 32'hFFFF_FFFF, 32'd0,          32'hFFFF_FFFF, 1};

    #1;
    check("reset stall", 32'(MulDivStall), 32'd0);
    check("reset done", 32'(MulDivDone), 32'd0);
    check("reset result", MulDivResult, 32'd0);
    check("reset wreg", 32'(MulDivWriteReg), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b0,
             vecs[i].exp_res, vecs[i].exp_stall);

    // Kill while the counter reads 10.
    @(posedge clk); #1;
    Funct3E = 3'd5; SrcAE = 32'd1000; SrcBE = 32'd7; WriteRegE = 5'd9; MulDivE = 1'b1;
    @(posedge clk); #1;
    MulDivE = 1'b0;
    repeat (10) @(posedge clk);
    #1 Kill = 1'b1;
    @(posedge clk); #1 Kill = 1'b0;
    @(negedge clk);
    check("kill stall", 32'(MulDivStall), 32'd0);
    check("kill done", 32'(MulDivDone), 32'd0);
    check("kill wreg", 32'(MulDivWriteReg), 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (MulDivDone) dones++;
    end
    check("kill no_done", 32'(dones), 32'd0);
    run_op("after_kill", 3'd5, 32'd9, 32'd3, 5'd4, 1'b0, 32'd3, 33);

    // Reset asserted mid-calculation.
    @(posedge clk); #1;
    Funct3E = 3'd4; SrcAE = 32'd12345; SrcBE = 32'd17; WriteRegE = 5'd7; MulDivE = 1'b1;
    @(posedge clk); #1;
    MulDivE = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst stall", 32'(MulDivStall), 32'd0);
    check("midrst done", 32'(MulDivDone), 32'd0);
    check("midrst result", MulDivResult, 32'd0);
    check("midrst wreg", 32'(MulDivWriteReg), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op("after_rst", 3'd4, 32'd12345, 32'd17, 5'd7, 1'b0, 32'd726, 33);

    // MulDivE held high through DONE: the next op goes in the following IDLE cycle.
    run_op("b2b_first", 3'd7, 32'd50, 32'd7, 5'd3, 1'b1, 32'd1, 33);
    run_op("b2b_second", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5, 1'b0, 32'h4000_0000, MUL_STALL);

    for (int n = 0; n < 40; n++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: ;
      endcase
      run_op($sformatf("rand%0d", n), rf, ra, rb, 5'($urandom_range(1, 31)), 1'b0,
             model(rf, ra, rb), exp_stall_of(rf, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_controller.md
MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port MulDivE, input, 1: M-extension op valid in Execute.
REQ-004 SHALL have port Funct3E, input, 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have ports SrcAE and SrcBE, input, 32 each: rs1 and rs2 operands, after forwarding.
REQ-006 SHALL have port WriteRegE, input, 5: destination register of the op.
REQ-007 SHALL have port Kill, input, 1: abort the in-flight op (branch or trap flush).
REQ-008 SHALL have port MulDivStall, output, 1: stall request, ORed into StallF/StallD, holds the Execute stage.
REQ-009 SHALL have port MulDivDone, output, 1: single-cycle pulse, result valid.
REQ-010 SHALL have port MulDivResult, output, 32: result, valid while MulDivDone=1, else 0.
REQ-011 SHALL have port MulDivWriteReg, output, 5: destination latched at accept, used by hazard compare.

Function
REQ-012 SHALL implement FSM IDLE, CALC, DONE, with a 5-bit iteration counter.
REQ-013 SHALL accept an op when state=IDLE and MulDivE=1 and Kill=0, latching Funct3E, WriteRegE and operand magnitudes.
REQ-014 SHALL assert MulDivStall combinationally in the accept cycle and in every CALC cycle, and deassert it in DONE.
REQ-015 SHALL go IDLE->CALC on accept, counter=0; CALC does one radix-2 step per cycle; at counter=31 it goes ->DONE; DONE->IDLE unconditionally.
REQ-016 SHALL give DIV/REM and iterative MUL a stall of 33 cycles, with MulDivDone in the 34th cycle after accept.
REQ-017 SHALL use restoring division on magnitudes; quotient negated iff DIV and operand signs differ; remainder takes the dividend sign.
REQ-018 SHALL form MUL = product[31:0] and MULH/MULHSU/MULHU = product[63:32]; MULHSU treats A as signed and B as unsigned.
REQ-019 SHALL, on divide by zero, skip CALC and go accept->DONE: quotient 0xFFFFFFFF, remainder = SrcAE.
REQ-020 SHALL, on signed overflow (0x80000000 / -1), go accept->DONE: DIV 0x80000000, REM 0.
REQ-021 SHALL, when Kill=1 in any state, go to IDLE next cycle, suppress MulDivDone, and give Kill priority over accept.
REQ-022 SHALL ignore MulDivE outside IDLE; back-to-back ops are accepted in the IDLE cycle that follows DONE.
REQ-023 SHALL hold MulDivWriteReg at 0 when IDLE, so x0 never matches a hazard.

Reset
REQ-024 SHALL, when rst_n=0, asynchronously force state=IDLE, counter=0, all operand/result registers 0, and MulDivStall, MulDivDone, MulDivResult, MulDivWriteReg all 0.
REQ-025 SHALL, if reset is asserted mid-CALC, discard the op without a MulDivDone pulse; the first accept after release behaves normally.

Configuration
REQ-026 SHALL have macro MULDIV_FAST_MUL_EN: when defined, MUL-class ops use a single-cycle 33x33 signed multiplier, go accept->DONE (1 stall cycle), MulDivDone in cycle 2.
REQ-027 SHALL, when MULDIV_FAST_MUL_EN is undefined, compute MUL-class ops by 32-step shift-add in the shared datapath, with REQ-016 latency.

Structure
REQ-028 SHALL put in package muldiv_pkg: state_t enum, Funct3 localparams, MULDIV_ITER=32, MULDIV_DIV0_Q=32'hFFFFFFFF.
REQ-029 SHALL use one sub-module muldiv_shift_core: 64-bit accumulator and shift register, one step per enable, mode mul/div; FSM stays in muldiv_controller.

Verification
REQ-030 SHALL cover: DIV SrcAE=-7, SrcBE=2 -> 33 stall cycles, MulDivDone in cycle 34, result 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
REQ-031 SHALL cover: DIVU 100/0 -> 1 stall cycle, result 0xFFFFFFFF; REMU 100/0 -> result 100.
REQ-032 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000; REM same operands -> 0.
REQ-033 SHALL cover: MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF; stall 1 cycle with MULDIV_FAST_MUL_EN defined, 33 cycles without.
REQ-034 SHALL cover: Kill at CALC counter=10 -> IDLE next cycle, no MulDivDone, MulDivStall=0; a new DIVU 9/3 then returns 3.
REQ-035 SHALL cover: rst_n low mid-CALC -> all outputs 0 immediately; MulDivE held high with Kill=0 through DONE -> second op accepted in the following IDLE cycle.
